unidade_controle_jogo: RTL and testbench

UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

---
 rtl/jogo_pkg.sv | 21 ++
 rtl/unidade_controle_jogo_if.sv | 29 ++
 rtl/detector_borda.sv | 25 ++
 rtl/unidade_controle_jogo.sv | 90 +++++++++
 tb/tb_unidade_controle_jogo.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared state codes and default round length for the game controller
//
// Purpose : state encoding (also shown on db_estado) and the default number
//           of memory positions checked per round.
// Ports   : none (package).
package jogo_pkg;

  localparam int n_posicoes_padrao = 16;

  typedef enum logic [3:0] {
    est_inicial       = 4'h0,
    est_preparacao    = 4'h1,
    est_espera_jogada = 4'h2,
    est_registra      = 4'h4,
    est_comparacao    = 4'h5,
    est_proximo       = 4'h6,
    est_fim_acerto    = 4'hA,
    est_fim_erro      = 4'hE
  } estado_t;

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// rtl/unidade_controle_jogo_if.sv - player/memory/status bundle of the game controller
//
// Purpose : groups the round control, play, memory and status signals.
// Ports   : master drives iniciar, jogada, chaves, dado_memoria and observes
//           endereco, pronto, acertou, errou, db_estado; slave is the controller.
interface unidade_controle_jogo_if;
  import jogo_pkg::*;

  logic       iniciar;
  logic       jogada;
  logic [3:0] chaves;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, chaves, dado_memoria,
    input  endereco, pronto, acertou, errou, db_estado
  );

  modport slave (
    input  iniciar, jogada, chaves, dado_memoria,
    output endereco, pronto, acertou, errou, db_estado
  );

endinterface

// File: rtl/detector_borda.sv
// rtl/detector_borda.sv - rising-edge detector for the play strobe
//
// Purpose : one-cycle pulse when entrada is sampled high after a low sample.
// Ports   : clock, reset (async, active-high), entrada (level), pulso (edge pulse).
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);

  logic anterior;

  // History is updated every cycle regardless of the consumer, so an edge
  // that is not consumed immediately is lost rather than queued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) anterior <= 1'b0;
    else       anterior <= entrada;
  end

  // Combinational pulse: the FSM reacts at the same edge that first samples
  // jogada high, which keeps the play-to-result latency at three edges.
  assign pulso = entrada & ~anterior;

endmodule

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - round controller comparing plays against memory contents
//
// Purpose : walks endereco through N_POSICOES memory positions, latches one
//           play per position and compares it with dado_memoria.
// Ports   : clock, reset (async, active-high); jogo (slave modport):
//           iniciar, jogada, chaves, dado_memoria in; endereco, pronto,
//           acertou, errou, db_estado out.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int N_POSICOES = n_posicoes_padrao
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_jogo_if.slave  jogo
);

  localparam logic [3:0] ultimo = 4'(N_POSICOES - 1);

  estado_t    estado;
  estado_t    estado_seg;
  logic [3:0] endereco_q;
  logic [3:0] jogada_q;
  logic       borda;
  logic       pronto_q;
  logic       acertou_q;
  logic       errou_q;

  detector_borda u_borda (
    .clock   (clock),
    .reset   (reset),
    .entrada (jogo.jogada),
    .pulso   (borda)
  );

  always_comb begin
    estado_seg = estado;
    case (estado)
      est_inicial:       if (jogo.iniciar) estado_seg = est_preparacao;
      est_preparacao:    estado_seg = est_espera_jogada;
      est_espera_jogada: if (borda) estado_seg = est_registra;
      est_registra:      estado_seg = est_comparacao;
      est_comparacao: begin
        if (jogada_q != jogo.dado_memoria) estado_seg = est_fim_erro;
        else if (endereco_q == ultimo)     estado_seg = est_fim_acerto;
        else                               estado_seg = est_proximo;
      end
      est_proximo:       estado_seg = est_espera_jogada;
      est_fim_acerto,
      est_fim_erro:      if (jogo.iniciar) estado_seg = est_preparacao;
      default:           estado_seg = est_inicial;
    endcase
  end

  // Flags are decoded from the next state so they change together with
  // db_estado while still coming straight out of flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= est_inicial;
      endereco_q <= 4'h0;
      jogada_q   <= 4'h0;
      pronto_q   <= 1'b0;
      acertou_q  <= 1'b0;
      errou_q    <= 1'b0;
    end else begin
      estado <= estado_seg;
      case (estado)
        est_preparacao: begin
          endereco_q <= 4'h0;
          jogada_q   <= 4'h0;
        end
        est_registra: jogada_q <= jogo.chaves;
        // proximo is only entered below ultimo; the guard keeps the counter
        // from wrapping even so.
        est_proximo:  if (endereco_q != ultimo) endereco_q <= endereco_q + 4'h1;
        default: ;
      endcase
      pronto_q  <= (estado_seg == est_fim_acerto) || (estado_seg == est_fim_erro);
      acertou_q <= (estado_seg == est_fim_acerto);
      errou_q   <= (estado_seg == est_fim_erro);
    end
  end

  assign jogo.endereco  = endereco_q;
  assign jogo.db_estado = estado;
  assign jogo.pronto    = pronto_q;
  assign jogo.acertou   = acertou_q;
  assign jogo.errou     = errou_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb/tb_unidade_controle_jogo.sv - directed bench for the game round controller
module tb_unidade_controle_jogo;
  import jogo_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  unidade_controle_jogo_if ifc ();
  unidade_controle_jogo_if ifc1 ();

  logic [3:0] mem [16];
  logic [3:0] mem1;

  assign ifc.dado_memoria  = mem[ifc.endereco];
  assign ifc1.dado_memoria = mem1;

  unidade_controle_jogo u_dut (
    .clock (clock),
    .reset (reset),
    .jogo  (ifc.slave)
  );

  unidade_controle_jogo #(.N_POSICOES(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .jogo  (ifc1.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One-cycle strobe; returns after the third edge (result state).
  task automatic play(input logic [3:0] v);
    ifc.chaves = v;
    ifc.jogada = 1'b1;
    tick;
    ifc.jogada = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    ifc.iniciar  = 1'b0; ifc.jogada  = 1'b0; ifc.chaves  = 4'h0;
    ifc1.iniciar = 1'b0; ifc1.jogada = 1'b0; ifc1.chaves = 4'h0;
    mem[0] = 4'h3; mem[1] = 4'h7; mem[2] = 4'h1;
    for (int i = 3; i < 16; i++) mem[i] = 4'((i * 5 + 2) & 15);
    mem1 = 4'h9;

    // reset state
    tick; tick;
    chk("rst_estado", ifc.db_estado, 4'h0);
    chk("rst_end", ifc.endereco, 4'h0);
    chk("rst_pronto", ifc.pronto, 1'b0);
    chk("rst_acertou", ifc.acertou, 1'b0);
    chk("rst_errou", ifc.errou, 1'b0);
    reset = 1'b0;
    tick;
    chk("idle_no_iniciar", ifc.db_estado, 4'h0);

    // scenario 1: sixteen correct plays
    ifc.iniciar = 1'b1;
    tick;
    chk("s1_prep", ifc.db_estado, 4'h1);
    ifc.iniciar = 1'b0;
    tick;
    chk("s1_espera0", ifc.db_estado, 4'h2);
    for (int i = 0; i < 16; i++) begin
      play(mem[i]);
      if (i < 15) begin
        chk("s1_proximo", ifc.db_estado, 4'h6);
        tick;
        chk("s1_espera", ifc.db_estado, 4'h2);
        chk("s1_end", ifc.endereco, 32'(i + 1));
      end
    end
    chk("s1_fim", ifc.db_estado, 4'hA);
    chk("s1_pronto", ifc.pronto, 1'b1);
    chk("s1_acertou", ifc.acertou, 1'b1);
    chk("s1_errou", ifc.errou, 1'b0);
    chk("s1_end_f", ifc.endereco, 4'hF);
    // strobes in a final state are discarded and the address stays frozen
    ifc.jogada = 1'b1; tick; tick;
    ifc.jogada = 1'b0; tick;
    chk("s1_hold", ifc.db_estado, 4'hA);
    chk("s1_hold_end", ifc.endereco, 4'hF);

    // asynchronous reset clears flags without waiting for an edge
    #2 reset = 1'b1;
    #1;
    chk("async_estado", ifc.db_estado, 4'h0);
    chk("async_pronto", ifc.pronto, 1'b0);
    chk("async_acertou", ifc.acertou, 1'b0);
    chk("async_end", ifc.endereco, 4'h0);
    tick;
    reset = 1'b0;
    tick;

    // scenario 2: 3 then 5 against 3,7
    ifc.iniciar = 1'b1;
    tick;
    ifc.iniciar = 1'b0;
    tick;
    chk("s2_espera", ifc.db_estado, 4'h2);
    play(4'h3);
    chk("s2_proximo", ifc.db_estado, 4'h6);
    tick;
    chk("s2_end1", ifc.endereco, 4'h1);
    play(4'h5);
    chk("s2_fim", ifc.db_estado, 4'hE);
    chk("s2_errou", ifc.errou, 1'b1);
    chk("s2_pronto", ifc.pronto, 1'b1);
    chk("s2_acertou", ifc.acertou, 1'b0);
    chk("s2_end", ifc.endereco, 4'h1);
    tick;
    chk("s2_hold", ifc.db_estado, 4'hE);

    // scenario 5: restart from fim_erro
    ifc.iniciar = 1'b1;
    tick;
    chk("s5_prep", ifc.db_estado, 4'h1);
    chk("s5_errou_prep", ifc.errou, 1'b0);
    chk("s5_pronto_prep", ifc.pronto, 1'b0);
    ifc.iniciar = 1'b0;
    tick;
    chk("s5_espera", ifc.db_estado, 4'h2);
    chk("s5_end", ifc.endereco, 4'h0);
    chk("s5_errou", ifc.errou, 1'b0);

    // scenario 3: jogada held high for 10 cycles counts once
    ifc.chaves = 4'h3;
    ifc.jogada = 1'b1;
    repeat (10) tick;
    chk("s3_estado", ifc.db_estado, 4'h2);
    chk("s3_end", ifc.endereco, 4'h1);
    ifc.jogada = 1'b0;
    tick;
    ifc.iniciar = 1'b1;
    tick;
    ifc.iniciar = 1'b0;
    chk("s3_iniciar_ignored", ifc.db_estado, 4'h2);
    chk("s3_end_kept", ifc.endereco, 4'h1);

    // scenario 4: reset mid-round at endereco 5
    for (int i = 1; i < 5; i++) begin
      play(mem[i]);
      tick;
    end
    chk("s4_end5", ifc.endereco, 4'h5);
    chk("s4_espera", ifc.db_estado, 4'h2);
    #2 reset = 1'b1;
    #1;
    chk("s4_estado", ifc.db_estado, 4'h0);
    chk("s4_end", ifc.endereco, 4'h0);
    chk("s4_flags", {ifc.pronto, ifc.acertou, ifc.errou}, 3'b000);
    // strobe activity during reset must not start anything afterwards
    tick;
    ifc.jogada = 1'b1; tick;
    ifc.jogada = 1'b0; tick;
    ifc.jogada = 1'b1; tick;
    reset = 1'b0;
    tick; tick;
    chk("s4_after_rst", ifc.db_estado, 4'h0);
    ifc.iniciar = 1'b1;
    tick;
    ifc.iniciar = 1'b0;
    tick; tick; tick;
    chk("s4_held_no_edge", ifc.db_estado, 4'h2);
    ifc.jogada = 1'b0;
    tick;

    // scenario 6: single-position round, three edges to fim_acerto
    ifc1.iniciar = 1'b1;
    tick;
    ifc1.iniciar = 1'b0;
    tick;
    chk("s6_espera", ifc1.db_estado, 4'h2);
    ifc1.chaves = 4'h9;
    ifc1.jogada = 1'b1;
    tick;
    chk("s6_registra", ifc1.db_estado, 4'h4);
    ifc1.jogada = 1'b0;
    tick;
    chk("s6_comparacao", ifc1.db_estado, 4'h5);
    tick;
    chk("s6_fim", ifc1.db_estado, 4'hA);
    chk("s6_acertou", ifc1.acertou, 1'b1);
    chk("s6_end", ifc1.endereco, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
